// File: rtl/sysserv_pkg.sv
// Shared types and constants for the system-services command master.
package sysserv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_SETUP,
    ST_CMD_ACCESS,
    ST_POLL_SETUP,
    ST_POLL_ACCESS,
    ST_RD_SETUP,
    ST_RD_ACCESS,
    ST_OUT_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SLVERR  = 2'd1;
  localparam logic [1:0] ERR_CMD     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] DEF_CMD_ADDR  = 32'h0000_0000;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0004;
  localparam logic [31:0] DEF_MBX_ADDR  = 32'h0000_0100;

  // Byte address of mailbox word idx; full 32-bit add, no wrap inside the window.
  function automatic logic [31:0] mbx_word_addr(input logic [31:0] base, input logic [4:0] idx);
    return base + {25'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sysserv_cmd_master_xfer.sv
// Single APB3 transfer engine. The owner holds i_req high for the whole
// transfer; the first requested cycle is SETUP, following cycles are ACCESS
// until PREADY. Holding i_req through the ack cycle starts a new SETUP.
module apb_master_xfer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_slverr,
  output logic [31:0] APBM_PADDR,
  output logic        APBM_PSEL,
  output logic        APBM_PENABLE,
  output logic        APBM_PWRITE,
  output logic [31:0] APBM_PWDATA,
  input  logic [31:0] APBM_PRDATA,
  input  logic        APBM_PREADY,
  input  logic        APBM_PSLVERR
);

  logic r_access;

  // ACCESS phase flag: set after one SETUP cycle, cleared when the slave completes.
  always_ff @(posedge CLK) begin
    if (RESET)                      r_access <= 1'b0;
    else if (!i_req)                r_access <= 1'b0;
    else if (!r_access)             r_access <= 1'b1;
    else if (APBM_PREADY)           r_access <= 1'b0;
  end

  assign APBM_PSEL    = i_req;
  assign APBM_PENABLE = r_access;
  assign APBM_PADDR   = i_addr;
  assign APBM_PWRITE  = i_wr;
  assign APBM_PWDATA  = i_wdata;

  assign o_ack    = i_req & r_access & APBM_PREADY;
  assign o_rdata  = APBM_PRDATA;
  assign o_slverr = o_ack & APBM_PSLVERR;

endmodule

// File: rtl/sysserv_cmd_master.sv
// APB3 master sequencing one system-services request: write the command,
// poll status until not busy (bounded by a timeout), read the response
// mailbox word by word and hand each word out over valid/ready.
module sysserv_cmd_master
  import sysserv_pkg::*;
#(
  parameter logic [31:0] CMD_ADDR    = DEF_CMD_ADDR,
  parameter logic [31:0] STAT_ADDR   = DEF_STAT_ADDR,
  parameter logic [31:0] MBX_ADDR    = DEF_MBX_ADDR,
  parameter int unsigned BUSY_BIT    = 0,
  parameter int unsigned ERR_BIT     = 1,
  parameter int unsigned MAX_WORDS   = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_start,
  input  logic [7:0]  cmd_opcode,
  input  logic [4:0]  cmd_nwords,
  output logic        cmd_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        done,
  output logic [1:0]  err,
  input  logic        SS_BUSY,
  output logic [31:0] APBM_PADDR,
  output logic        APBM_PSEL,
  output logic        APBM_PENABLE,
  output logic        APBM_PWRITE,
  output logic [31:0] APBM_PWDATA,
  input  logic [31:0] APBM_PRDATA,
  input  logic        APBM_PREADY,
  input  logic        APBM_PSLVERR
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_paddr, r_pwdata, r_tmo_cnt, r_rsp_data;
  logic        r_pwrite, r_rsp_valid;
  logic [4:0]  r_nwords, r_idx, w_idx_inc, w_rd_idx;
  logic [1:0]  r_err, w_fin_code;
  logic        w_req, w_ack, w_slverr, w_tmo, w_polling, w_cmd_ready;
  logic        w_accept, w_ld_poll, w_ld_rd, w_fin, w_rsp_load, w_rsp_pop;
  logic [31:0] w_rdata;

  apb_master_xfer u_xfer (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_req        (w_req),
    .i_addr       (r_paddr),
    .i_wr         (r_pwrite),
    .i_wdata      (r_pwdata),
    .o_ack        (w_ack),
    .o_rdata      (w_rdata),
    .o_slverr     (w_slverr),
    .APBM_PADDR   (APBM_PADDR),
    .APBM_PSEL    (APBM_PSEL),
    .APBM_PENABLE (APBM_PENABLE),
    .APBM_PWRITE  (APBM_PWRITE),
    .APBM_PWDATA  (APBM_PWDATA),
    .APBM_PRDATA  (APBM_PRDATA),
    .APBM_PREADY  (APBM_PREADY),
    .APBM_PSLVERR (APBM_PSLVERR)
  );

  assign w_req = (r_state == ST_CMD_SETUP)  || (r_state == ST_CMD_ACCESS)  ||
                 (r_state == ST_POLL_SETUP) || (r_state == ST_POLL_ACCESS) ||
                 (r_state == ST_RD_SETUP)   || (r_state == ST_RD_ACCESS);
  assign w_polling   = (r_state == ST_POLL_SETUP) || (r_state == ST_POLL_ACCESS);
  assign w_tmo       = (r_tmo_cnt >= 32'(TIMEOUT_CYC));
  assign w_idx_inc   = r_idx + 5'd1;
  // RESET gates ready so every output reads 0 while reset is held.
  assign w_cmd_ready = (r_state == ST_IDLE) && !SS_BUSY && !RESET;

  assign cmd_ready = w_cmd_ready;
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = r_rsp_valid;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ld_poll   = 1'b0;
    w_ld_rd     = 1'b0;
    w_rd_idx    = r_idx;
    w_fin       = 1'b0;
    w_fin_code  = ERR_OK;
    w_rsp_load  = 1'b0;
    w_rsp_pop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start && w_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CMD_SETUP;
        end
      end
      ST_CMD_SETUP:  w_state_nxt = ST_CMD_ACCESS;
      ST_CMD_ACCESS: begin
        if (w_ack) begin
          if (w_slverr) begin
            w_fin = 1'b1; w_fin_code = ERR_SLVERR;
          end else begin
            w_ld_poll = 1'b1; w_state_nxt = ST_POLL_SETUP;
          end
        end
      end
      ST_POLL_SETUP: w_state_nxt = ST_POLL_ACCESS;
      ST_POLL_ACCESS: begin
        if (w_ack) begin
          if (w_slverr) begin
            w_fin = 1'b1; w_fin_code = ERR_SLVERR;
          end else if (!w_rdata[BUSY_BIT]) begin
            if (w_rdata[ERR_BIT]) begin
              w_fin = 1'b1; w_fin_code = ERR_CMD;
            end else if (r_nwords == 5'd0) begin
              w_fin = 1'b1; w_fin_code = ERR_OK;
            end else begin
              w_ld_rd = 1'b1; w_rd_idx = 5'd0; w_state_nxt = ST_RD_SETUP;
            end
          end else if (w_tmo) begin
            w_fin = 1'b1; w_fin_code = ERR_TIMEOUT;
          end else begin
            w_ld_poll = 1'b1; w_state_nxt = ST_POLL_SETUP;
          end
        end
      end
      ST_RD_SETUP: w_state_nxt = ST_RD_ACCESS;
      ST_RD_ACCESS: begin
        if (w_ack) begin
          if (w_slverr) begin
            w_fin = 1'b1; w_fin_code = ERR_SLVERR;
          end else begin
            w_rsp_load = 1'b1; w_state_nxt = ST_OUT_WAIT;
          end
        end
      end
      ST_OUT_WAIT: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_pop = 1'b1;
          if (w_idx_inc == r_nwords) begin
            w_fin = 1'b1; w_fin_code = ERR_OK;
          end else begin
            w_ld_rd = 1'b1; w_rd_idx = w_idx_inc; w_state_nxt = ST_RD_SETUP;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_fin) w_state_nxt = ST_DONE;
  end

  // Transfer address/data, request bookkeeping, timeout counter and response holding.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_paddr     <= 32'd0;
      r_pwdata    <= 32'd0;
      r_pwrite    <= 1'b0;
      r_nwords    <= 5'd0;
      r_idx       <= 5'd0;
      r_tmo_cnt   <= 32'd0;
      r_err       <= ERR_OK;
      r_rsp_data  <= 32'd0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_nwords  <= (cmd_nwords > 5'(MAX_WORDS)) ? 5'(MAX_WORDS) : cmd_nwords;
        r_err     <= ERR_OK;
        r_tmo_cnt <= 32'd0;
        r_paddr   <= CMD_ADDR;
        r_pwrite  <= 1'b1;
        r_pwdata  <= {24'b0, cmd_opcode};
      end
      if (w_ld_poll) begin
        r_paddr  <= STAT_ADDR;
        r_pwrite <= 1'b0;
      end
      if (w_ld_rd) begin
        r_paddr  <= mbx_word_addr(MBX_ADDR, w_rd_idx);
        r_pwrite <= 1'b0;
        r_idx    <= w_rd_idx;
      end
      if (w_polling && !w_tmo) r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (w_fin) r_err <= w_fin_code;
      if (w_rsp_load) begin
        r_rsp_data  <= w_rdata;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_pop) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sysserv_cmd_master.sv
// Scoreboard bench for sysserv_cmd_master with a behavioural APB slave.
module tb_sysserv_cmd_master;

  localparam logic [31:0] CMD_A  = 32'h0000_0000;
  localparam logic [31:0] STAT_A = 32'h0000_0004;
  localparam logic [31:0] MBX_A  = 32'h0000_0100;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        cmd_start = 1'b0, rsp_ready = 1'b0, SS_BUSY = 1'b0;
  logic [7:0]  cmd_opcode = 8'd0;
  logic [4:0]  cmd_nwords = 5'd0;
  logic        cmd_ready, rsp_valid, done;
  logic [31:0] rsp_data;
  logic [1:0]  err;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  sysserv_cmd_master #(.TIMEOUT_CYC(100)) dut (
    .CLK(CLK), .RESET(RESET), .cmd_start(cmd_start), .cmd_opcode(cmd_opcode),
    .cmd_nwords(cmd_nwords), .cmd_ready(cmd_ready), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .done(done), .err(err),
    .SS_BUSY(SS_BUSY), .APBM_PADDR(PADDR), .APBM_PSEL(PSEL), .APBM_PENABLE(PENABLE),
    .APBM_PWRITE(PWRITE), .APBM_PWDATA(PWDATA), .APBM_PRDATA(PRDATA),
    .APBM_PREADY(PREADY), .APBM_PSLVERR(PSLVERR));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave scenario and observations
  int busy_left = 0, slverr_rd = -1, rd_cnt = 0, max_wait = 0, wait_cnt = 0;
  bit stuck = 0, stat_err = 0, hold_rd = 0;
  logic [31:0] mbx [32];
  logic [31:0] cmd_wr = 32'hFFFF_FFFF;

  // Scoreboard
  logic [31:0] exp_words [$];
  logic [1:0]  exp_err [$];
  int          exp_reads [$];
  logic [31:0] exp_cmd [$];
  int n_done = 0, viol = 0, cyc = 0, first_poll = -1;
  bit tmo_chk = 0;
  int rdy_mode = 0, bp_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural APB slave: random wait states, status/mailbox contents from scenario.
  initial begin
    PREADY = 0; PRDATA = 0; PSLVERR = 0;
    forever begin
      @(posedge CLK); #1;
      PREADY = 0; PSLVERR = 0; PRDATA = 32'd0;
      if (PSEL && !PENABLE) wait_cnt = $urandom_range(0, max_wait);
      else if (PSEL && PENABLE) begin
        if (wait_cnt > 0) wait_cnt--;
        else if (hold_rd && !PWRITE && PADDR >= MBX_A) PREADY = 0;
        else begin
          PREADY = 1;
          if (PWRITE) begin
            if (PADDR == CMD_A) cmd_wr = PWDATA;
          end else if (PADDR == STAT_A) begin
            if (stuck || busy_left > 0) begin
              PRDATA = {30'd0, 1'($urandom_range(0, 1)), 1'b1};
              if (busy_left > 0) busy_left--;
            end else PRDATA = stat_err ? 32'h2 : 32'h0;
          end else begin
            logic [31:0] off;
            off = (PADDR - MBX_A) >> 2;
            PRDATA = mbx[off[4:0]];
            if (rd_cnt == slverr_rd) PSLVERR = 1;
            rd_cnt++;
          end
        end
      end
    end
  end

  // Consumer: always ready, 10-cycle backpressure per word, or random.
  initial begin
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0: rsp_ready = 1;
        1: begin
          if (rsp_valid) begin
            if (bp_cnt >= 10) rsp_ready = 1; else begin rsp_ready = 0; bp_cnt++; end
          end else begin rsp_ready = 0; bp_cnt = 0; end
        end
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output event, tallies protocol violations.
  initial begin
    bit p_valid, p_pop, p_ack, p_done;
    logic [31:0] p_data;
    p_valid = 0; p_pop = 0; p_ack = 0; p_done = 0; p_data = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (rsp_valid && PSEL) viol++;
        if (p_valid && !p_pop && (!rsp_valid || rsp_data !== p_data)) viol++;
        if (p_ack && PENABLE) viol++;
        if (p_done && done) viol++;
        if (PSEL && !PENABLE && !PWRITE && PADDR == STAT_A && first_poll < 0) first_poll = cyc;
        if (rsp_valid && rsp_ready) begin
          if (exp_words.size() == 0) chk("unexpected_rsp", rsp_data, 32'hDEAD_BEEF);
          else chk("rsp_word", rsp_data, exp_words.pop_front());
        end
        if (done) begin
          n_done++;
          if (exp_err.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
          else begin
            chk("done_err", 32'(err), 32'(exp_err.pop_front()));
            chk("mbx_reads", rd_cnt, exp_reads.pop_front());
            chk("cmd_written", cmd_wr, exp_cmd.pop_front());
            chk("words_left", exp_words.size(), 0);
            if (tmo_chk) chk("tmo_latency_le_104", 32'(cyc - first_poll <= 104), 32'd1);
          end
        end
      end
      p_valid = rsp_valid; p_pop = rsp_valid && rsp_ready; p_data = rsp_data;
      p_ack = PSEL && PENABLE && PREADY; p_done = done;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(posedge CLK); #1;
    while (!cmd_ready && n < 200) begin @(posedge CLK); #1; n++; end
    if (!cmd_ready) chk("wait_cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // One request: model the expected outcome from the scenario, then issue it.
  task automatic run_cmd(input logic [7:0] op, input int nw_req, input int busy, input bit serr,
                         input bit stk, input int sv_rd, input int mw, input bit sn, input bit tchk);
    int nw, nout, reads, d0, n;
    logic [1:0] e;
    for (int i = 0; i < 32; i++) mbx[i] = sn ? (32'hA0 + 32'(i)) : $urandom;
    nw = (nw_req > 16) ? 16 : nw_req;
    if (stk)                          begin e = 2'd3; nout = 0;     reads = 0; end
    else if (serr)                    begin e = 2'd2; nout = 0;     reads = 0; end
    else if (sv_rd >= 0 && sv_rd < nw) begin e = 2'd1; nout = sv_rd; reads = sv_rd + 1; end
    else                              begin e = 2'd0; nout = nw;    reads = nw; end
    wait_ready();
    busy_left = busy; stat_err = serr; stuck = stk; slverr_rd = sv_rd; max_wait = mw;
    rd_cnt = 0; cmd_wr = 32'hFFFF_FFFF; viol = 0; first_poll = -1; tmo_chk = tchk;
    for (int i = 0; i < nout; i++) exp_words.push_back(mbx[i]);
    exp_err.push_back(e); exp_reads.push_back(reads); exp_cmd.push_back({24'd0, op});
    d0 = n_done;
    cmd_start = 1; cmd_opcode = op; cmd_nwords = 5'(nw_req);
    @(posedge CLK); #1;
    cmd_start = 0;
    chk("first_psel_latency", {PSEL, PENABLE, PWRITE, cmd_ready}, 4'b1010);
    chk("cmd_paddr", PADDR, CMD_A);
    n = 0;
    while (n_done == d0 && n < 3000) begin @(posedge CLK); #1; n++; end
    if (n_done == d0) chk("done_wait_timeout", 32'(n_done), 32'(d0 + 1));
    @(posedge CLK); #1;
    chk("err_held", 32'(err), 32'(e));
    chk("protocol_violations", viol, 0);
  endtask

  initial begin
    int d0, n;
    bit seen;
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outputs", {cmd_ready, done, err, rsp_valid, PSEL, PENABLE, PWRITE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    @(posedge CLK); #1; RESET = 0; #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Serial-number read
    rdy_mode = 0;
    run_cmd(8'h00, 4, 3, 0, 0, -1, 0, 1, 0);
    // Backpressure
    rdy_mode = 1;
    run_cmd(8'h01, 4, 1, 0, 0, -1, 1, 0, 0);
    rdy_mode = 0;
    // Command error
    run_cmd(8'h05, 4, 2, 1, 0, -1, 1, 0, 0);
    // PSLVERR on second mailbox read
    run_cmd(8'h07, 4, 0, 0, 0, 1, 1, 0, 0);
    // Clamp above 16 words and zero-word request
    run_cmd(8'h11, 25, 0, 0, 0, -1, 0, 0, 0);
    run_cmd(8'h12, 0, 1, 0, 0, -1, 0, 0, 0);
    // Timeout with busy stuck
    run_cmd(8'h0E, 4, 0, 0, 1, -1, 0, 0, 1);
    // Randomized requests
    rdy_mode = 2;
    for (int k = 0; k < 12; k++)
      run_cmd(8'($urandom), $urandom_range(0, 22), $urandom_range(0, 4),
              ($urandom_range(0, 5) == 0), 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1, 2, 0, 0);
    rdy_mode = 0;

    // Start while not ready is ignored
    SS_BUSY = 1; d0 = n_done;
    @(posedge CLK); #1; cmd_start = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(posedge CLK); #1; cmd_start = 0; if (PSEL) seen = 1; end
    chk("ignored_start_psel", 32'(seen), 32'd0);
    chk("ignored_start_done", n_done, d0);
    SS_BUSY = 0;

    // Reset in the middle of a stalled mailbox read
    exp_words.delete(); exp_err.delete(); exp_reads.delete(); exp_cmd.delete();
    wait_ready();
    hold_rd = 1; busy_left = 0; stat_err = 0; stuck = 0; slverr_rd = -1; max_wait = 0;
    d0 = n_done;
    cmd_start = 1; cmd_opcode = 8'h22; cmd_nwords = 5'd3;
    @(posedge CLK); #1; cmd_start = 0;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(negedge CLK); n++;
      if (PSEL && PENABLE && !PWRITE && PADDR == MBX_A) seen = 1;
    end
    chk("reach_rd_access", 32'(seen), 32'd1);
    RESET = 1;
    @(posedge CLK); #1;
    chk("psel_after_mid_reset", {PSEL, PENABLE, done}, 32'd0);
    repeat (2) @(posedge CLK);
    #1; RESET = 0; hold_rd = 0; #1;
    chk("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
    SS_BUSY = 1; #1;
    chk("ss_busy_blocks_ready", 32'(cmd_ready), 32'd0);
    repeat (5) @(posedge CLK);
    chk("no_done_after_reset", n_done, d0);
    SS_BUSY = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
